mem_seq_fsm: RTL and testbench

MEM_SEQ_FSM -- requirements
Module: mem_seq_fsm

---
 rtl/img_pkg.sv | 31 +++
 rtl/delay_line.sv | 42 ++++
 rtl/mem_seq_fsm.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_seq_fsm.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// -----------------------------------------------------------------------------
// img_pkg
// Shared definitions for the image pipeline: the control block, the memory
// sequencer and the convolver all agree on these defaults and on the sequencer
// state encoding.
//   ADDR_W_DEF    default row address width
//   N_BANKS_DEF   default column banks per stripe
//   PIPE_LAT_DEF  default convolver latency after a valid bank output
//   seq_state_t   sequencer state encoding
//   bank_width()  index width for a bank count (never below one bit)
// -----------------------------------------------------------------------------
package img_pkg;

    localparam int ADDR_W_DEF   = 10;
    localparam int N_BANKS_DEF  = 3;
    localparam int PIPE_LAT_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FULL  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } seq_state_t;

    function automatic int bank_width(input int n_banks);
        return (n_banks > 1) ? $clog2(n_banks) : 1;
    endfunction

endpackage

// File: rtl/delay_line.sv
// -----------------------------------------------------------------------------
// delay_line
// Parameterised shift register with synchronous clear. data_out reproduces
// data_in exactly DEPTH cycles later. DEPTH must be at least 1.
// Ports:
//   i_CLK     clock
//   i_rst     synchronous active-high reset, clears every tap
//   data_in   WIDTH-bit input
//   data_out  WIDTH-bit input delayed by DEPTH cycles
// -----------------------------------------------------------------------------
module delay_line
    import img_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             i_CLK,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] taps [DEPTH];

    // Clearing the taps on reset means a pulse in flight never escapes after
    // the sequencer has been sent back to IDLE.
    always_ff @(posedge i_CLK) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                taps[i] <= '0;
            end
        end else begin
            taps[0] <= data_in;
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign data_out = taps[DEPTH-1];

endmodule

// File: rtl/mem_seq_fsm.sv
// -----------------------------------------------------------------------------
// mem_seq_fsm
// Memory sequencer for one image stripe. In load mode it writes incoming
// pixels column by column into N_BANKS line-buffer banks; in run mode it
// reads all banks in parallel row by row, then waits for the convolver
// pipeline to drain and raises end-of-process.
// Ports:
//   i_CLK         clock
//   i_rst         synchronous active-high reset
//   i_load        load-mode level from the control block
//   i_run         run-mode level from the control block (wins over i_valid)
//   i_valid       one-cycle pixel strobe
//   i_data        pixel
//   i_imgLength   pixels per column, captured when a load starts
//   o_we          one-hot bank write enable
//   o_wr_addr     write row
//   o_wr_data     write pixel
//   o_rd_en       read all banks
//   o_rd_addr     read row
//   o_conv_valid  bank outputs valid (o_rd_en one cycle later)
//   o_EOP         end of process (level while DONE)
//   o_full        stripe fully loaded
//   o_overflow    sticky: a pixel was dropped because the stripe was full
// PIPE_LAT must be at least 1.
// -----------------------------------------------------------------------------
module mem_seq_fsm
    import img_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int N_BANKS  = N_BANKS_DEF,
    parameter int PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic               i_CLK,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic               i_run,
    input  logic               i_valid,
    input  logic [7:0]         i_data,
    input  logic [ADDR_W-1:0]  i_imgLength,
    output logic [N_BANKS-1:0] o_we,
    output logic [ADDR_W-1:0]  o_wr_addr,
    output logic [7:0]         o_wr_data,
    output logic               o_rd_en,
    output logic [ADDR_W-1:0]  o_rd_addr,
    output logic               o_conv_valid,
    output logic               o_EOP,
    output logic               o_full,
    output logic               o_overflow
);

    localparam int BANK_W = bank_width(N_BANKS);

    seq_state_t        state;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] len;
    logic [BANK_W-1:0] bank;
    logic              full_q;
    logic              overflow_q;

    logic len_zero;
    logic row_last;
    logic bank_last;
    logic write_en;
    logic drop_pixel;
    logic enter_run;
    logic drain_start;
    logic drain_done;

    // row_last is only consulted when len is non-zero, so the wrap of
    // len-1 for a zero length never matters.
    assign len_zero  = (len == '0);
    assign row_last  = (row == (len - ADDR_W'(1)));
    assign bank_last = (bank == BANK_W'(N_BANKS - 1));
    assign enter_run = ((state == ST_LOAD) || (state == ST_FULL)) && i_run;

    // A strobe is written only while loading a non-empty column and run mode
    // is not being requested in the same cycle.
    assign write_en = (state == ST_LOAD) && i_valid && !i_run && !len_zero;

    // A strobe that has nowhere to go marks the overflow; a zero-length
    // stripe counts as already full.
    assign drop_pixel = i_valid && !i_run &&
                        ((state == ST_FULL) || ((state == ST_LOAD) && len_zero));

    // The drain countdown starts on the cycle the last row is read, or, for
    // a zero-length stripe, on the cycle run mode is accepted.
    assign drain_start = ((state == ST_RUN) && row_last) || (enter_run && len_zero);

    // Write-side outputs follow the registered counters and the live pixel so
    // the bank write lands in the same cycle as the strobe.
    always_comb begin
        o_we      = '0;
        o_wr_addr = '0;
        o_wr_data = '0;
        if (write_en) begin
            o_we[bank] = 1'b1;
            o_wr_addr  = row;
            o_wr_data  = i_data;
        end
    end

    assign o_rd_en    = (state == ST_RUN);
    assign o_rd_addr  = o_rd_en ? row : '0;
    assign o_EOP      = (state == ST_DONE);
    assign o_full     = full_q;
    assign o_overflow = overflow_q;

    // Bank outputs become valid one cycle after the read, matching the
    // block-RAM read latency.
    delay_line #(
        .DEPTH (1),
        .WIDTH (1)
    ) u_conv_delay (
        .i_CLK    (i_CLK),
        .i_rst    (i_rst),
        .data_in  (o_rd_en),
        .data_out (o_conv_valid)
    );

    // drain_done fires PIPE_LAT cycles after the last read so that DONE is
    // reached 1+PIPE_LAT cycles after it.
    delay_line #(
        .DEPTH (PIPE_LAT),
        .WIDTH (1)
    ) u_drain_delay (
        .i_CLK    (i_CLK),
        .i_rst    (i_rst),
        .data_in  (drain_start),
        .data_out (drain_done)
    );

    // Sequencer: one counter serves as write row in LOAD and read row in RUN.
    // The terminal compare happens before the increment, so the counters wrap
    // deliberately and never overflow. o_overflow is only cleared by reset.
    always_ff @(posedge i_CLK) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            row        <= '0;
            bank       <= '0;
            len        <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (drop_pixel) begin
                overflow_q <= 1'b1;
            end

            unique case (state)
                ST_IDLE: begin
                    if (i_load) begin
                        state  <= ST_LOAD;
                        row    <= '0;
                        bank   <= '0;
                        len    <= i_imgLength;
                        full_q <= 1'b0;
                    end
                end

                ST_LOAD: begin
                    if (i_run) begin
                        state <= len_zero ? ST_DRAIN : ST_RUN;
                        row   <= '0;
                    end else if (len_zero) begin
                        state  <= ST_FULL;
                        full_q <= 1'b1;
                    end else if (i_valid) begin
                        if (row_last) begin
                            row <= '0;
                            if (bank_last) begin
                                state  <= ST_FULL;
                                full_q <= 1'b1;
                            end else begin
                                bank <= bank + BANK_W'(1);
                            end
                        end else begin
                            row <= row + ADDR_W'(1);
                        end
                    end
                end

                ST_FULL: begin
                    if (i_run) begin
                        state <= len_zero ? ST_DRAIN : ST_RUN;
                        row   <= '0;
                    end
                end

                ST_RUN: begin
                    if (row_last) begin
                        state <= ST_DRAIN;
                        row   <= '0;
                    end else begin
                        row <= row + ADDR_W'(1);
                    end
                end

                ST_DRAIN: begin
                    if (drain_done) begin
                        state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    if (i_load && !i_run) begin
                        state  <= ST_LOAD;
                        row    <= '0;
                        bank   <= '0;
                        len    <= i_imgLength;
                        full_q <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_seq_fsm.sv
// -----------------------------------------------------------------------------
// tb_mem_seq_fsm
// Scoreboard bench for mem_seq_fsm. Each stimulus cycle updates a stripe-level
// model (pixels loaded so far, sticky overflow, when the run finishes) and
// pushes the write, read, conv-valid and end-of-process events it implies,
// each tagged with its cycle. A negedge monitor pops and compares whenever
// the DUT presents one of those events.
// -----------------------------------------------------------------------------
module tb_mem_seq_fsm;
    import img_pkg::*;

    localparam int ADDR_W   = 10;
    localparam int N_BANKS  = 3;
    localparam int PIPE_LAT = 3;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_BUSY = 2;
    localparam int M_DONE = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               load;
    logic               run;
    logic               valid;
    logic [7:0]         data;
    logic [ADDR_W-1:0]  img_len;
    logic [N_BANKS-1:0] we;
    logic [ADDR_W-1:0]  wr_addr;
    logic [7:0]         wr_data;
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic               conv_valid;
    logic               eop;
    logic               full;
    logic               overflow;

    mem_seq_fsm #(
        .ADDR_W   (ADDR_W),
        .N_BANKS  (N_BANKS),
        .PIPE_LAT (PIPE_LAT)
    ) dut (
        .i_CLK        (clk),
        .i_rst        (rst),
        .i_load       (load),
        .i_run        (run),
        .i_valid      (valid),
        .i_data       (data),
        .i_imgLength  (img_len),
        .o_we         (we),
        .o_wr_addr    (wr_addr),
        .o_wr_data    (wr_data),
        .o_rd_en      (rd_en),
        .o_rd_addr    (rd_addr),
        .o_conv_valid (conv_valid),
        .o_EOP        (eop),
        .o_full       (full),
        .o_overflow   (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                 at;
        logic [N_BANKS-1:0] we;
        logic [ADDR_W-1:0]  addr;
        logic [7:0]         data;
    } wr_t;

    typedef struct {
        int                at;
        logic [ADDR_W-1:0] addr;
    } rd_t;

    wr_t wr_q[$];
    rd_t rd_q[$];
    int  conv_q[$];
    int  eop_q[$];

    int checks = 0;
    int fails  = 0;

    int   m_mode = M_IDLE;
    int   m_len  = 0;
    int   m_n    = 0;
    logic m_ov   = 1'b0;
    int   m_done = 0;

    bit   mon_en   = 1'b0;
    logic prev_eop = 1'b0;
    wr_t  wr_e;
    rd_t  rd_e;
    int   ev;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs and let the stripe model decide what the DUT
    // should do with them.
    task automatic applyStimulus(input logic l, input logic r, input logic v,
                                 input logic [7:0] d, input logic [ADDR_W-1:0] len_in);
        wr_t                w;
        rd_t                rr;
        logic [N_BANKS-1:0] oh;
        load    = l;
        run     = r;
        valid   = v;
        data    = d;
        img_len = len_in;

        if (m_mode == M_BUSY && cyc >= m_done) m_mode = M_DONE;

        case (m_mode)
            M_IDLE, M_DONE: begin
                if (l && !(m_mode == M_DONE && r)) begin
                    m_mode = M_LOAD;
                    m_len  = int'(len_in);
                    m_n    = 0;
                end
            end
            M_LOAD: begin
                if (r) begin
                    for (int k = 0; k < m_len; k++) begin
                        rr.at   = cyc + 1 + k;
                        rr.addr = ADDR_W'(k);
                        rd_q.push_back(rr);
                        conv_q.push_back(cyc + 2 + k);
                    end
                    m_done = cyc + m_len + 1 + PIPE_LAT;
                    eop_q.push_back(m_done);
                    m_mode = M_BUSY;
                end else if (v) begin
                    if (m_len != 0 && m_n < m_len * N_BANKS) begin
                        oh     = '0;
                        oh[m_n / m_len] = 1'b1;
                        w.at   = cyc;
                        w.we   = oh;
                        w.addr = ADDR_W'(m_n % m_len);
                        w.data = d;
                        wr_q.push_back(w);
                        m_n++;
                    end else begin
                        m_ov = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        tick();
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'($urandom % 2), 8'($urandom), ADDR_W'($urandom));
    endtask

    // Drop every expected event scheduled after the current cycle; the reset
    // edge at the end of this cycle cancels them.
    task automatic purgeFuture();
        wr_t w_keep[$];
        rd_t r_keep[$];
        int  c_keep[$];
        int  e_keep[$];
        foreach (wr_q[i])   if (wr_q[i].at <= cyc) w_keep.push_back(wr_q[i]);
        foreach (rd_q[i])   if (rd_q[i].at <= cyc) r_keep.push_back(rd_q[i]);
        foreach (conv_q[i]) if (conv_q[i] <= cyc)  c_keep.push_back(conv_q[i]);
        foreach (eop_q[i])  if (eop_q[i] <= cyc)   e_keep.push_back(eop_q[i]);
        wr_q   = w_keep;
        rd_q   = r_keep;
        conv_q = c_keep;
        eop_q  = e_keep;
    endtask

    task automatic doReset(input int n);
        rst   = 1'b1;
        load  = 1'b0;
        run   = 1'b0;
        valid = 1'b0;
        purgeFuture();
        m_mode = M_IDLE;
        m_ov   = 1'b0;
        m_n    = 0;
        for (int i = 0; i < n; i++) tick();
        checkOutput("rst_we", we, 0);
        checkOutput("rst_wr_addr", wr_addr, 0);
        checkOutput("rst_rd_en", rd_en, 0);
        checkOutput("rst_rd_addr", rd_addr, 0);
        checkOutput("rst_conv_valid", conv_valid, 0);
        checkOutput("rst_eop", eop, 0);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_overflow", overflow, 0);
        rst = 1'b0;
    endtask

    task automatic waitDone();
        for (int g = 0; g < 300 && cyc < m_done; g++) idleCycle();
        checkOutput("eop_level", eop, 1);
        checkOutput("overflow_done", overflow, m_ov);
    endtask

    // Monitor: every write, read, conv-valid and EOP rise must match the
    // oldest expectation of its kind, including the cycle it occurs in.
    always @(negedge clk) begin
        if (mon_en) begin
            if (we !== '0) begin
                checkOutput("wr_expected", wr_q.size() != 0, 1);
                if (wr_q.size() != 0) begin
                    wr_e = wr_q.pop_front();
                    checkOutput("wr_cycle", cyc, wr_e.at);
                    checkOutput("wr_we", we, wr_e.we);
                    checkOutput("wr_addr", wr_addr, wr_e.addr);
                    checkOutput("wr_data", wr_data, wr_e.data);
                end
            end
            if (rd_en === 1'b1) begin
                checkOutput("rd_expected", rd_q.size() != 0, 1);
                if (rd_q.size() != 0) begin
                    rd_e = rd_q.pop_front();
                    checkOutput("rd_cycle", cyc, rd_e.at);
                    checkOutput("rd_addr", rd_addr, rd_e.addr);
                end
            end
            if (conv_valid === 1'b1) begin
                checkOutput("conv_expected", conv_q.size() != 0, 1);
                if (conv_q.size() != 0) begin
                    ev = conv_q.pop_front();
                    checkOutput("conv_cycle", cyc, ev);
                end
            end
            if (eop === 1'b1 && prev_eop !== 1'b1) begin
                checkOutput("eop_expected", eop_q.size() != 0, 1);
                if (eop_q.size() != 0) begin
                    ev = eop_q.pop_front();
                    checkOutput("eop_cycle", cyc, ev);
                end
            end
            prev_eop = eop;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int nstrobe;
        int len_r;
        rst     = 1'b1;
        load    = 1'b0;
        run     = 1'b0;
        valid   = 1'b0;
        data    = '0;
        img_len = '0;
        tick();
        mon_en = 1'b1;
        doReset(3);

        // Full stripe of 4-pixel columns, pixels 1..12
        $display("[TB] directed load, length 4");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, ADDR_W'(4));
        for (int i = 1; i <= 12; i++) begin
            if (i == 12) checkOutput("full_before_last", full, 0);
            applyStimulus(1'b0, 1'b0, 1'b1, 8'(i), ADDR_W'(4));
        end
        checkOutput("full_after_12", full, 1);
        checkOutput("overflow_after_12", overflow, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd13, ADDR_W'(4));
        checkOutput("overflow_13th", overflow, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, ADDR_W'(7));
        waitDone();
        checkOutput("overflow_sticky", overflow, 1);

        // Reset mid-RUN on the row-2 read, then reload from bank 0 row 0
        $display("[TB] reset during run");
        doReset(2);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, ADDR_W'(4));
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'($urandom), ADDR_W'(4));
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, ADDR_W'(4));
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, ADDR_W'(4));
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, ADDR_W'(4));
        checkOutput("rd_addr_row2", rd_addr, 2);
        doReset(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, ADDR_W'(3));
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'($urandom), ADDR_W'(3));

        // Run and strobe together: run wins, the pixel is neither written
        // nor counted as an overflow
        $display("[TB] run with simultaneous strobe");
        applyStimulus(1'b0, 1'b1, 1'b1, 8'hA5, ADDR_W'(3));
        checkOutput("overflow_run_strobe", overflow, 0);
        waitDone();

        // Zero-length stripe
        $display("[TB] zero length");
        doReset(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, ADDR_W'(0));
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h3C, ADDR_W'(0));
        checkOutput("overflow_zero_len", overflow, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, ADDR_W'(0));
        waitDone();

        // Random stripes restarted from DONE
        $display("[TB] random stripes");
        for (int it = 0; it < 8; it++) begin
            len_r = int'($urandom_range(0, 5));
            applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, ADDR_W'(len_r));
            nstrobe = int'($urandom_range(0, len_r * N_BANKS + 2));
            for (int s = 0; s < nstrobe; s++) begin
                for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
                    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, ADDR_W'($urandom));
                end
                applyStimulus(1'b0, 1'b0, 1'b1, 8'($urandom), ADDR_W'($urandom));
            end
            if (len_r != 0) checkOutput("full_random", full, m_n == len_r * N_BANKS);
            checkOutput("overflow_random", overflow, m_ov);
            applyStimulus(1'b0, 1'b1, 1'($urandom % 2), 8'($urandom), ADDR_W'($urandom));
            waitDone();
        end

        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, '0);
        checkOutput("wr_q_left", wr_q.size(), 0);
        checkOutput("rd_q_left", rd_q.size(), 0);
        checkOutput("conv_q_left", conv_q.size(), 0);
        checkOutput("eop_q_left", eop_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
